// File: rtl/display_uart_pkg.sv
// Shared types, constants and character helpers for the display UART transmitter.
package display_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;
  localparam int unsigned LINE_CHARS = 10;
  localparam int unsigned CHAR_IDX_W = 4;

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

  // Character idx of a line: eight hex digits MSB-first, then CR, LF.
  function automatic logic [7:0] line_char(input logic [31:0] word,
                                           input logic [CHAR_IDX_W-1:0] idx);
    logic [7:0] ch;
    if (idx == CHAR_IDX_W'(LINE_CHARS - 2)) begin
      ch = ASCII_CR;
    end else if (idx == CHAR_IDX_W'(LINE_CHARS - 1)) begin
      ch = ASCII_LF;
    end else begin
      ch = nib_to_ascii(word[{3'd7 - idx[2:0], 2'b00} +: 4]);
    end
    return ch;
  endfunction

endpackage

// File: rtl/display_uart_tx_byte.sv
// 8N1 byte serializer: holds the baud and bit counters; chains bytes with no idle gap.
module uart_byte_tx
  import display_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       txd_o,
  output logic       busy_o,
  output logic       done_c_o
);

  localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             bit_end_c;

  assign bit_end_c = (baud_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    done_c_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_START;
          shift_d    = data_i;
          baud_cnt_d = '0;
        end
      end
      ST_START: begin
        baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          done_c_o = 1'b1;
          // A start in the last stop clock chains straight into the next start bit.
          if (start_i) begin
            state_d = ST_START;
            shift_d = data_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign txd_o  = txd_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/display_uart_tx.sv
// Sends the display word as "XXXXXXXX\r\n" over UART whenever it changes or on force_send.
module display_uart_tx
  import display_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display_value,
  input  logic        force_send,
  output logic        uart_txd,
  output logic        busy,
  output logic        pending
);

  logic [31:0]           last_value_q;
  logic [31:0]           line_buf_q, line_buf_d;
  logic [31:0]           pend_buf_q, pend_buf_d;
  logic                  pending_q, pending_d;
  logic [CHAR_IDX_W-1:0] char_idx_q, char_idx_d;
  logic                  req_c, last_char_c;
  logic                  tx_start_c, tx_done_c, tx_busy;
  logic [7:0]            tx_byte_c;

  assign req_c       = (display_value != last_value_q) || force_send;
  assign last_char_c = (char_idx_q == CHAR_IDX_W'(LINE_CHARS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_value_q <= '0;
      line_buf_q   <= '0;
      pend_buf_q   <= '0;
      pending_q    <= 1'b0;
      char_idx_q   <= '0;
    end else begin
      last_value_q <= display_value;
      line_buf_q   <= line_buf_d;
      pend_buf_q   <= pend_buf_d;
      pending_q    <= pending_d;
      char_idx_q   <= char_idx_d;
    end
  end

  // Line sequencing: a fresh request at line end beats the pending buffer.
  always_comb begin
    line_buf_d = line_buf_q;
    pend_buf_d = pend_buf_q;
    pending_d  = pending_q;
    char_idx_d = char_idx_q;
    tx_start_c = 1'b0;
    tx_byte_c  = 8'h00;
    if (!tx_busy) begin
      if (req_c) begin
        line_buf_d = display_value;
        char_idx_d = '0;
        tx_start_c = 1'b1;
        tx_byte_c  = line_char(display_value, CHAR_IDX_W'(0));
      end
    end else if (tx_done_c && !last_char_c) begin
      char_idx_d = char_idx_q + CHAR_IDX_W'(1);
      tx_start_c = 1'b1;
      tx_byte_c  = line_char(line_buf_q, char_idx_d);
      if (req_c) begin
        pend_buf_d = display_value;
        pending_d  = 1'b1;
      end
    end else if (tx_done_c) begin
      char_idx_d = '0;
      if (req_c) begin
        line_buf_d = display_value;
        pending_d  = 1'b0;
        tx_start_c = 1'b1;
        tx_byte_c  = line_char(display_value, CHAR_IDX_W'(0));
      end else if (pending_q) begin
        line_buf_d = pend_buf_q;
        pending_d  = 1'b0;
        tx_start_c = 1'b1;
        tx_byte_c  = line_char(pend_buf_q, CHAR_IDX_W'(0));
      end
    end else if (req_c) begin
      pend_buf_d = display_value;
      pending_d  = 1'b1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (tx_start_c),
    .data_i  (tx_byte_c),
    .txd_o   (uart_txd),
    .busy_o  (tx_busy),
    .done_c_o(tx_done_c)
  );

  assign busy    = tx_busy;
  assign pending = pending_q;

endmodule
